// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: shifts words out MSB-first into a PAT_W-bit pattern detector and counts matches per frame.
// Latency: DATA_W shift cycles per accepted word; done pulses the cycle after the last bit of the last word.
// Backpressure: in_ready is low while shifting and during DONE. Optional abort/aborted ports via SEQ_SCAN_ABORT_EN.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
`ifdef SEQ_SCAN_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int IDX_W  = $clog2(DATA_W);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W:0]  PAT_LEN = (FILL_W + 1)'(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              done_q;
  logic              in_frame_q;
  logic              last_q;
  logic              overlap_q;
  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  hist_q;
  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [FILL_W:0]   fill_inc;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              hit;
  logic              abort_w;
  logic              abort_hit;
  logic              accept;

`ifdef SEQ_SCAN_ABORT_EN
  logic aborted_q;
  assign abort_w = abort;
  assign aborted = aborted_q;
`else
  assign abort_w = 1'b0;
`endif

  // Abort only matters mid-shift or between words of an open frame; a word offered alongside it is refused.
  assign abort_hit   = abort_w && ((state_q == SHIFT) || ((state_q == IDLE) && in_frame_q));
  assign in_ready    = in_ready_q && !abort_hit;
  assign accept      = in_valid && in_ready;
  assign match       = (state_q == SHIFT) && !abort_hit && hit;
  assign match_count = count_q;
  assign done        = done_q;

  // Detector next-state for the bit currently selected out of the held word.
  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], word_q[bit_idx_q]};
    fill_inc = {1'b0, fill_q} + (FILL_W + 1)'(1);
    hit      = (hist_d == pattern_q) && (fill_inc >= PAT_LEN);
    if (hit && !overlap_q) begin
      fill_d = '0;
    end else if (fill_inc >= PAT_LEN) begin
      fill_d = PAT_LEN[FILL_W-1:0];
    end else begin
      fill_d = fill_inc[FILL_W-1:0];
    end
    count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
  end

  // Frame FSM with registered handshake/done outputs; detector state is reset at each frame's first word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      in_frame_q <= 1'b0;
      last_q     <= 1'b0;
      overlap_q  <= 1'b0;
      word_q     <= '0;
      bit_idx_q  <= '0;
      pattern_q  <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
`ifdef SEQ_SCAN_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (abort_hit) begin
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
`ifdef SEQ_SCAN_ABORT_EN
            aborted_q  <= 1'b1;
`endif
          end else if (accept) begin
            word_q     <= in_data;
            last_q     <= in_last;
            bit_idx_q  <= IDX_TOP;
            state_q    <= SHIFT;
            in_ready_q <= 1'b0;
            if (!in_frame_q) begin
              pattern_q  <= cfg_pattern;
              overlap_q  <= cfg_overlap;
              hist_q     <= '0;
              fill_q     <= '0;
              count_q    <= '0;
              in_frame_q <= 1'b1;
`ifdef SEQ_SCAN_ABORT_EN
              aborted_q  <= 1'b0;
`endif
            end
          end
        end
        SHIFT: begin
          if (abort_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
`ifdef SEQ_SCAN_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            if (hit) begin
              count_q <= count_d;
            end
            if (bit_idx_q == '0) begin
              if (last_q) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q    <= IDLE;
                in_ready_q <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q - IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          in_frame_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: fixed vector table, hand-written multi-word/reset sequences, random frames vs a bit-stream model.
// A second instance with CNT_W=2 shares all inputs and checks counter saturation.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_last;
  logic       cfg_overlap;
  logic [7:0] in_data;
  logic [2:0] cfg_pattern;
  logic       in_ready, match, done;
  logic [7:0] match_count;
  logic       in_ready2, match2, done2;
  logic [1:0] match_count2;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int prev_cnt = 0;

  logic [7:0] fw[$];
  bit         em[$];
  int         ecnt;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(3), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .match(match), .match_count(match_count), .done(done)
  );

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .match(match2), .match_count(match_count2), .done(done2)
  );

  // Count handshakes and done pulses as seen at the clock edge.
  always @(posedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) acc_cnt++;
      if (done) done_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected strobes from the frame's bit stream: a match ends wherever the last 3 bits equal the
  // pattern, and in non-overlapping mode at least 3 bits after the previous match's end.
  function automatic void model(input logic [2:0] pat, input bit ovl);
    bit bits[$];
    int last_m;
    bit h;
    bits.delete();
    foreach (fw[w]) for (int j = 7; j >= 0; j--) bits.push_back(fw[w][j]);
    em.delete();
    ecnt   = 0;
    last_m = -100;
    for (int i = 0; i < bits.size(); i++) begin
      h = (i >= 2) && ({bits[i-2], bits[i-1], bits[i]} == pat) && (ovl || (i - last_m >= 3));
      em.push_back(h);
      if (h) begin
        ecnt++;
        last_m = i;
      end
    end
  endfunction

  task automatic run_frame(input logic [2:0] pat, input bit ovl, input int gap_max, input bit chg_cfg);
    int a0, d0, pos, tries, nw;
    a0  = acc_cnt;
    d0  = done_cnt;
    pos = 0;
    nw  = fw.size();
    chk("count_hold", match_count, prev_cnt);
    cfg_pattern = pat;
    cfg_overlap = ovl;
    for (int w = 0; w < nw; w++) begin
      in_valid = 1'b1;
      in_data  = fw[w];
      in_last  = (w == nw - 1);
      tries = 0;
      while (!in_ready && tries < 40) begin
        @(negedge clk);
        tries++;
      end
      chk("accept_rdy", in_ready, 1);
      @(negedge clk);
      if (chg_cfg) begin
        cfg_pattern = 3'($urandom);
        cfg_overlap = 1'($urandom);
      end
      if (gap_max == 0 && w + 1 < nw) begin
        in_data = fw[w+1];
        in_last = (w + 1 == nw - 1);
      end else begin
        in_valid = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        chk("match", match, em[pos]);
        chk("match_b", match2, em[pos]);
        if (k == 4) begin
          chk("rdy_shift", in_ready, 0);
          chk("rdy_shift_b", in_ready2, 0);
        end
        pos++;
      end
      @(negedge clk);
      if (w == nw - 1) begin
        chk("done_hi", done, 1);
        chk("done_hi_b", done2, 1);
        chk("rdy_done", in_ready, 0);
        chk("count", match_count, ecnt);
        chk("count_sat", match_count2, (ecnt > 3) ? 3 : ecnt);
        @(negedge clk);
        chk("done_lo", done, 0);
        chk("rdy_idle", in_ready, 1);
      end else begin
        chk("done_mid", done, 0);
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
    end
    chk("accepts", acc_cnt - a0, nw);
    chk("dones", done_cnt - d0, 1);
    prev_cnt = ecnt;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [2:0] pat;
    bit         ovl;
    logic [7:0] mask;   // bit k set = match expected in shift cycle k
    int         cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'b1010_1010, 3'b101, 1'b1, 8'h54, 3};
    tbl[1] = '{8'b1010_1010, 3'b101, 1'b0, 8'h44, 2};
    tbl[2] = '{8'hFF,        3'b111, 1'b1, 8'hFC, 6};
    tbl[3] = '{8'hFF,        3'b111, 1'b0, 8'h24, 2};
    tbl[4] = '{8'b0000_0101, 3'b101, 1'b1, 8'h80, 1};
    tbl[5] = '{8'h00,        3'b000, 1'b0, 8'h24, 2};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b0;
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_match", match, 0);
    chk("rst_count", match_count, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1);

    // Single-word frames from the table.
    for (int v = 0; v < 6; v++) begin
      fw.delete();
      fw.push_back(tbl[v].data);
      em.delete();
      for (int k = 0; k < 8; k++) em.push_back(tbl[v].mask[k]);
      ecnt = tbl[v].cnt;
      run_frame(tbl[v].pat, tbl[v].ovl, 0, 1'b0);
    end

    // Match spanning a word boundary: one match on word 2's first bit.
    fw.delete();
    fw.push_back(8'b0000_0010);
    fw.push_back(8'b1000_0000);
    em.delete();
    for (int i = 0; i < 16; i++) em.push_back(i == 8);
    ecnt = 1;
    run_frame(3'b101, 1'b1, 2, 1'b0);

    // Producer holds valid continuously across three words.
    fw.delete();
    fw.push_back(8'b1011_0110);
    fw.push_back(8'b1101_1011);
    fw.push_back(8'b0110_1101);
    model(3'b110, 1'b0);
    run_frame(3'b110, 1'b0, 0, 1'b1);

    // Reset in the middle of a shifting frame, then a clean frame.
    @(negedge clk);
    cfg_pattern = 3'b111; cfg_overlap = 1'b1;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_match", match, 1);
    reset = 1'b1;
    #1;
    chk("arst_match", match, 0);
    chk("arst_count", match_count, 0);
    chk("arst_count_b", match_count2, 0);
    chk("arst_done", done, 0);
    chk("arst_rdy", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev_cnt = 0;
    @(negedge clk);
    fw.delete();
    fw.push_back(8'b0000_0101);
    model(3'b101, 1'b1);
    run_frame(3'b101, 1'b1, 0, 1'b0);

    // Random frames; config inputs are scrambled mid-frame and must be ignored.
    for (int f = 0; f < 30; f++) begin
      logic [2:0] p;
      bit         o;
      int         n;
      n = $urandom_range(1, 4);
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back(8'($urandom));
      p = 3'($urandom);
      o = 1'($urandom);
      model(p, o);
      run_frame(p, o, (f % 2 == 0) ? 0 : 3, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
